// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer: waits for a safe fetch boundary, injects the
// push/jump sequence into IF/ID, drains, then tracks ISR residency until RTI.
// Optional build macro IRQ_COUNT_EN adds a saturating irq_count output.
module interrupt_sequencer #(
  parameter int              PC_W          = 32,
  parameter int              INST_W        = 16,
  parameter logic [INST_W-1:0] PUSH_PCH_INST = 16'hC010,
  parameter logic [INST_W-1:0] PUSH_PCL_INST = 16'hC018,
  parameter logic [INST_W-1:0] PUSH_FLG_INST = 16'hC020,
  parameter logic [INST_W-1:0] JMP_VEC_INST  = 16'hF800,
  parameter int              DRAIN_CYC     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              irq,
  input  logic              fetch_two_word,
  input  logic              branch_pending,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              ret_seen,
  output logic              inject_valid,
  output logic [INST_W-1:0] inject_inst,
  output logic              inject_bubble,
  output logic              fetch_stall,
  output logic              push_flags,
  output logic              restore_flags,
  output logic [PC_W-1:0]   saved_pc,
  output logic              in_isr,
  output logic              irq_ack
`ifdef IRQ_COUNT_EN
  ,
  output logic [15:0]       irq_count
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WAIT  = 3'd1;
  localparam logic [2:0] PCH   = 3'd2;
  localparam logic [2:0] PCL   = 3'd3;
  localparam logic [2:0] FLG   = 3'd4;
  localparam logic [2:0] VEC   = 3'd5;
  localparam logic [2:0] DRAIN = 3'd6;
  localparam logic [2:0] ISR   = 3'd7;

  // Counter runs DRAIN_CYC-1 down to 0, giving exactly DRAIN_CYC bubble cycles.
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYC - 1);

  logic [2:0] state;
  logic [2:0] nextState;
  logic       pending;
  logic [2:0] drainCnt;
  logic       restoreQ;
  logic       enterPch;

  assign enterPch = (state == WAIT) && (nextState == PCH);

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (irq || pending) nextState = WAIT;
      WAIT:    if (!fetch_two_word && !branch_pending) nextState = PCH;
      PCH:     nextState = PCL;
      PCL:     nextState = FLG;
      FLG:     nextState = VEC;
      VEC:     nextState = DRAIN;
      DRAIN:   if (drainCnt == 3'd0) nextState = ISR;
      ISR:     if (ret_seen) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      saved_pc <= '0;
      pending  <= 1'b0;
      drainCnt <= 3'd0;
      restoreQ <= 1'b0;
    end else begin
      state    <= nextState;
      restoreQ <= (state == ISR) && ret_seen;
      if (enterPch) saved_pc <= pc_in;
      // A request during the ISR (including the RTI cycle) is held for re-entry.
      if ((state == ISR) && irq) pending <= 1'b1;
      else if (enterPch)         pending <= 1'b0;
      if (state == VEC)                             drainCnt <= DRAIN_LOAD;
      else if ((state == DRAIN) && (drainCnt != 0)) drainCnt <= drainCnt - 3'd1;
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    inject_valid  = 1'b0;
    inject_inst   = '0;
    inject_bubble = 1'b0;
    fetch_stall   = 1'b0;
    push_flags    = 1'b0;
    irq_ack       = 1'b0;
    case (state)
      PCH: begin
        inject_valid = 1'b1;
        inject_inst  = PUSH_PCH_INST;
        fetch_stall  = 1'b1;
        irq_ack      = 1'b1;
      end
      PCL: begin
        inject_valid = 1'b1;
        inject_inst  = PUSH_PCL_INST;
        fetch_stall  = 1'b1;
      end
      FLG: begin
        inject_valid = 1'b1;
        inject_inst  = PUSH_FLG_INST;
        fetch_stall  = 1'b1;
        push_flags   = 1'b1;
      end
      VEC: begin
        inject_valid = 1'b1;
        inject_inst  = JMP_VEC_INST;
        fetch_stall  = 1'b1;
      end
      DRAIN: begin
        inject_bubble = 1'b1;
        fetch_stall   = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_isr        = (state == ISR);
  assign restore_flags = restoreQ;

`ifdef IRQ_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_count <= 16'h0000;
    else if (irq_ack && (irq_count != 16'hFFFF)) irq_count <= irq_count + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: entry sequence, hold-offs, return,
// nested request and asynchronous reset, with immediate-assertion checks.
module tb_interrupt_sequencer;

  localparam logic [15:0] C_PCH = 16'hC010;
  localparam logic [15:0] C_PCL = 16'hC018;
  localparam logic [15:0] C_FLG = 16'hC020;
  localparam logic [15:0] C_VEC = 16'hF800;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq;
  logic        fetch_two_word;
  logic        branch_pending;
  logic [31:0] pc_in;
  logic        ret_seen;
  logic        inject_valid;
  logic [15:0] inject_inst;
  logic        inject_bubble;
  logic        fetch_stall;
  logic        push_flags;
  logic        restore_flags;
  logic [31:0] saved_pc;
  logic        in_isr;
  logic        irq_ack;
`ifdef IRQ_COUNT_EN
  logic [15:0] irq_count;
`endif

  int nCompared   = 0;
  int nMismatched = 0;
  int ackCount    = 0;
  int ackBase;

  interrupt_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .irq           (irq),
    .fetch_two_word(fetch_two_word),
    .branch_pending(branch_pending),
    .pc_in         (pc_in),
    .ret_seen      (ret_seen),
    .inject_valid  (inject_valid),
    .inject_inst   (inject_inst),
    .inject_bubble (inject_bubble),
    .fetch_stall   (fetch_stall),
    .push_flags    (push_flags),
    .restore_flags (restore_flags),
    .saved_pc      (saved_pc),
    .in_isr        (in_isr),
    .irq_ack       (irq_ack)
`ifdef IRQ_COUNT_EN
    ,
    .irq_count     (irq_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (irq_ack) ackCount++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s differs", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectOut(input string tag, input logic iv, input logic [15:0] inst,
                           input logic bub, input logic stall, input logic pf,
                           input logic rf, input logic isr, input logic ack);
    check({tag, ".inject_valid"},  32'(inject_valid),  32'(iv));
    check({tag, ".inject_inst"},   32'(inject_inst),   32'(inst));
    check({tag, ".inject_bubble"}, 32'(inject_bubble), 32'(bub));
    check({tag, ".fetch_stall"},   32'(fetch_stall),   32'(stall));
    check({tag, ".push_flags"},    32'(push_flags),    32'(pf));
    check({tag, ".restore_flags"}, 32'(restore_flags), 32'(rf));
    check({tag, ".in_isr"},        32'(in_isr),        32'(isr));
    check({tag, ".irq_ack"},       32'(irq_ack),       32'(ack));
  endtask

  // Called in WAIT with a safe boundary presented: the next edge enters PCH.
  task automatic runEntry(input string tag, input logic [31:0] expPc, input bit bpInSeq);
    step();
    expectOut({tag, ".pch"}, 1'b1, C_PCH, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check({tag, ".saved_pc_pch"}, saved_pc, expPc);
    if (bpInSeq) branch_pending = 1'b1;
    pc_in = 32'hDEAD_0000;
    step();
    expectOut({tag, ".pcl"}, 1'b1, C_PCL, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    expectOut({tag, ".flg"}, 1'b1, C_FLG, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    expectOut({tag, ".vec"}, 1'b1, C_VEC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    branch_pending = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expectOut($sformatf("%s.drain%0d", tag, i), 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step();
    expectOut({tag, ".isr"}, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check({tag, ".saved_pc_isr"}, saved_pc, expPc);
  endtask

  task automatic doReturn(input string tag);
    ret_seen = 1'b1;
    step();
    ret_seen = 1'b0;
    expectOut({tag, ".ret"}, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check({tag, ".rf_after"}, 32'(restore_flags), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    irq = 1'b0;
    fetch_two_word = 1'b0;
    branch_pending = 1'b0;
    pc_in = 32'h0;
    ret_seen = 1'b0;
    #1;
    expectOut("reset0", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset0.saved_pc", saved_pc, 32'h0);
`ifdef IRQ_COUNT_EN
    check("reset0.irq_count", 32'(irq_count), 32'd0);
`endif
    #11;
    reset = 1'b1;

    // Basic entry: one-cycle irq pulse at a safe point.
    pc_in = 32'h0000_0040;
    irq = 1'b1;
    step();
    irq = 1'b0;
    expectOut("basic.wait", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    runEntry("basic", 32'h0000_0040, 1'b0);

    // Return, then a stray ret_seen while idle.
    doReturn("ret");
    ret_seen = 1'b1;
    step();
    ret_seen = 1'b0;
    check("idle_ret.rf0", 32'(restore_flags), 32'd0);
    step();
    check("idle_ret.rf1", 32'(restore_flags), 32'd0);
    check("idle_ret.stall", 32'(fetch_stall), 32'd0);

    // Two-word hold-off: two blocked edges in WAIT, then safe.
    irq = 1'b1;
    fetch_two_word = 1'b1;
    pc_in = 32'h0000_0100;
    step();
    check("tw.wait0.iv", 32'(inject_valid), 32'd0);
    step();
    check("tw.wait1.iv", 32'(inject_valid), 32'd0);
    check("tw.wait1.stall", 32'(fetch_stall), 32'd0);
    fetch_two_word = 1'b0;
    irq = 1'b0;
    pc_in = 32'h0000_0104;
    runEntry("tw", 32'h0000_0104, 1'b0);
    doReturn("tw");

    // Branch hold-off in WAIT; branch_pending during the sequence is ignored.
    irq = 1'b1;
    branch_pending = 1'b1;
    pc_in = 32'h0000_0200;
    step();
    irq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("br.wait%0d.iv", i), 32'(inject_valid), 32'd0);
    end
    branch_pending = 1'b0;
    pc_in = 32'h0000_0204;
    runEntry("br", 32'h0000_0204, 1'b1);
    doReturn("br");

    // Nested request: irq during ISR re-enters after RTI without a new irq.
    ackBase = ackCount;
    irq = 1'b1;
    pc_in = 32'h0000_0300;
    step();
    irq = 1'b0;
    runEntry("nest1", 32'h0000_0300, 1'b0);
    irq = 1'b1;
    step();
    irq = 1'b0;
    check("nest.in_isr", 32'(in_isr), 32'd1);
    doReturn("nest");
    pc_in = 32'h0000_0310;
    runEntry("nest2", 32'h0000_0310, 1'b0);
    check("nest.ack_total", 32'(ackCount - ackBase), 32'd2);
`ifdef IRQ_COUNT_EN
    check("nest.irq_count", 32'(irq_count), 32'd5);
`endif
    doReturn("nest2");

    // Asynchronous reset in the FLG cycle.
    irq = 1'b1;
    pc_in = 32'h0000_0400;
    step();
    irq = 1'b0;
    step();
    step();
    step();
    check("rst.flg.pf", 32'(push_flags), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    expectOut("rst.async", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.async.saved_pc", saved_pc, 32'h0);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst.idle%0d.stall", i), 32'(fetch_stall), 32'd0);
    end

    // Reset with a request pending must drop that request.
    irq = 1'b1;
    pc_in = 32'h0000_0500;
    step();
    irq = 1'b0;
    runEntry("pend", 32'h0000_0500, 1'b0);
    irq = 1'b1;
    step();
    irq = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("pend.rst.in_isr", 32'(in_isr), 32'd0);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("pend.idle%0d.iv", i), 32'(inject_valid), 32'd0);
      check($sformatf("pend.idle%0d.stall", i), 32'(fetch_stall), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
